// File: rtl/program_sequencer_if.sv
// ---------------------------------------------------------------------------
// program_sequencer_if
//   Processor-side bus of the boot/program sequencer: the reset and start
//   strobes plus the valid/ready instruction write channel.
//   master : driven by the sequencer (cpu_reset, cpu_write, program_out,
//            cpu_start out; cpu_ready in)
//   slave  : seen by the processor core (directions mirrored)
// ---------------------------------------------------------------------------
interface program_sequencer_if #(
  parameter int INSTR_W = 23
);
  logic               cpu_reset;    // active-high reset to processor
  logic               cpu_write;    // instruction valid
  logic               cpu_ready;    // processor accepts instruction
  logic [INSTR_W-1:0] program_out;  // instruction word
  logic               cpu_start;    // start strobe

  modport master (
    output cpu_reset, cpu_write, program_out, cpu_start,
    input  cpu_ready
  );

  modport slave (
    input  cpu_reset, cpu_write, program_out, cpu_start,
    output cpu_ready
  );
endinterface

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
//   Boot sequencer for a simple processor core. Holds the core in reset,
//   streams a stored instruction image over a valid/ready write channel,
//   then pulses start for a fixed number of cycles.
//
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset of the sequencer
//   cfg_we      : write image[cfg_addr] <= cfg_data (only while idle/done)
//   cfg_addr    : image write address
//   cfg_data    : image write data
//   prog_len    : instructions to stream, sampled when go is accepted
//   go          : start a run (level, sampled each cycle while idle/done)
//   busy        : run in progress
//   done        : last run completed, sticky until the next accepted go
//   sent_count  : instructions transferred in the current/last run
//   bus         : processor side (cpu_reset, cpu_write, cpu_ready,
//                 program_out, cpu_start)
//
//   All outputs are registered; next-state decode drives the output flops
//   so every output changes together with the state it belongs to.
// ---------------------------------------------------------------------------
module program_sequencer #(
  parameter  int INSTR_W      = 23,
  parameter  int DEPTH        = 16,
  parameter  int RESET_CYCLES = 2,
  parameter  int START_CYCLES = 2,
  localparam int ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [INSTR_W-1:0]  cfg_data,
  input  logic [ADDR_W:0]     prog_len,
  input  logic                go,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     sent_count,
  program_sequencer_if.master bus
);

  localparam int LEN_W   = ADDR_W + 1;
  localparam int CNT_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_STREAM,
    S_START,
    S_DONE
  } state_e;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [ADDR_W-1:0]   idx_q,       idx_d;
  logic [LEN_W-1:0]    len_q,       len_d;
  logic [LEN_W-1:0]    sent_q,      sent_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                cpu_write_q, cpu_write_d;
  logic                cpu_start_q, cpu_start_d;
  logic [INSTR_W-1:0]  prog_q,      prog_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;

  logic [INSTR_W-1:0]  image_mem [DEPTH];

  logic                cfg_open;
  logic                transfer;
  logic [ADDR_W-1:0]   idx_next;
  logic [LEN_W-1:0]    len_clamped;

  // The image may only change between runs, so a stream always sees a
  // frozen copy; a write in the same cycle as an accepted go still lands
  // before streaming begins.
  assign cfg_open    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign transfer    = cpu_write_q & bus.cpu_ready;
  assign idx_next    = idx_q + ADDR_W'(1);
  assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;

  // NOTE: the image is plain storage with no reset; clearing it would
  // force a flop-per-bit array and the contents are meant to survive reset.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_open) begin
      image_mem[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the
  // case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    len_d       = len_q;
    sent_d      = sent_q;
    cpu_reset_d = cpu_reset_q;
    cpu_write_d = cpu_write_q;
    cpu_start_d = cpu_start_q;
    prog_d      = prog_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d     = S_RST_HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          len_d       = len_clamped;
          sent_d      = '0;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end

      S_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          cnt_d       = '0;
          cpu_reset_d = 1'b0;
          if (len_q != '0) begin
            state_d     = S_STREAM;
            cpu_write_d = 1'b1;
            prog_d      = image_mem[0];
          end else begin
            state_d     = S_START;
            cpu_start_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STREAM: begin
        // Without a transfer the word and valid simply hold (backpressure).
        if (transfer) begin
          if (sent_q < len_q) begin
            sent_d = sent_q + LEN_W'(1);
          end
          if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
            state_d     = S_START;
            cnt_d       = '0;
            cpu_write_d = 1'b0;
            prog_d      = '0;
            cpu_start_d = 1'b1;
          end else begin
            idx_d  = idx_next;
            prog_d = image_mem[idx_next];
          end
        end
      end

      S_START: begin
        if (cnt_q == START_LAST) begin
          state_d     = S_DONE;
          cpu_start_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      sent_q      <= '0;
      cpu_reset_q <= 1'b1;
      cpu_write_q <= 1'b0;
      cpu_start_q <= 1'b0;
      prog_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      sent_q      <= sent_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_write_q <= cpu_write_d;
      cpu_start_q <= cpu_start_d;
      prog_q      <= prog_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.cpu_write   = cpu_write_q;
  assign bus.cpu_start   = cpu_start_q;
  assign bus.program_out = prog_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign sent_count      = sent_q;

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
//   Directed bench for program_sequencer (INSTR_W=23, DEPTH=16, 2/2 cycles).
//   Expected instruction words are queued when a run is launched; a negedge
//   monitor pops and compares each accepted write, checks words stay stable
//   under backpressure and counts start-strobe cycles.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

  localparam int INSTR_W = 23;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [INSTR_W-1:0] cfg_data;
  logic [ADDR_W:0]    prog_len;
  logic               go;
  logic               busy;
  logic               done;
  logic [ADDR_W:0]    sent_count;

  program_sequencer_if #(.INSTR_W(INSTR_W)) bus ();

  program_sequencer #(
    .INSTR_W      (INSTR_W),
    .DEPTH        (DEPTH),
    .RESET_CYCLES (2),
    .START_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .prog_len   (prog_len),
    .go         (go),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [INSTR_W-1:0] exp_q [$];
  logic [INSTR_W-1:0] mon_exp;
  logic [INSTR_W-1:0] stall_val;
  logic               stall_prev = 1'b0;
  int                 write_cnt  = 0;
  int                 start_cnt  = 0;
  int                 hold_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: runs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset && bus.cpu_write) begin
      if (stall_prev) check("hold_stable", 32'(bus.program_out), 32'(stall_val));
      if (bus.program_out == 23'h000002) hold_cnt++;
      if (bus.cpu_ready) begin
        write_cnt++;
        stall_prev = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got %06h, required no write", bus.program_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("stream_word", 32'(bus.program_out), 32'(mon_exp));
        end
      end else begin
        stall_prev = 1'b1;
        stall_val  = bus.program_out;
      end
    end else begin
      stall_prev = 1'b0;
    end
    if (bus.cpu_start) start_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic clear_counts();
    write_cnt = 0;
    start_cnt = 0;
    hold_cnt  = 0;
  endtask

  // Drives go for one edge; returns 1ns after the accepting edge.
  task automatic issue_go(input logic [ADDR_W:0] len);
    prog_len = len;
    go       = 1'b1;
    tick();
    go       = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic end_of_run(input string tag, input int writes, input logic [ADDR_W:0] sent);
    check({tag, "_writes"},     32'(write_cnt),    32'(writes));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_start_cyc"},  32'(start_cnt),    32'd2);
    check({tag, "_sent"},       32'(sent_count),   32'(sent));
    check({tag, "_busy"},       32'(busy),         32'd0);
    check({tag, "_cpu_reset"},  32'(bus.cpu_reset), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_data      = '0;
    prog_len      = '0;
    go            = 1'b0;
    bus.cpu_ready = 1'b1;

    // Reset values.
    #12;
    check("rst_cpu_reset", 32'(bus.cpu_reset),   32'd1);
    check("rst_cpu_write", 32'(bus.cpu_write),   32'd0);
    check("rst_cpu_start", 32'(bus.cpu_start),   32'd0);
    check("rst_prog_out",  32'(bus.program_out), 32'd0);
    check("rst_busy",      32'(busy),            32'd0);
    check("rst_done",      32'(done),            32'd0);
    check("rst_sent",      32'(sent_count),      32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Image[i] = i+1 for every entry.
    for (int i = 0; i < DEPTH; i++) cfg_write(ADDR_W'(i), INSTR_W'(i + 1));
    check("idle_cpu_reset", 32'(bus.cpu_reset), 32'd1);

    // Basic run: 3 words, ready always high.
    clear_counts();
    exp_q.push_back(23'h000001);
    exp_q.push_back(23'h000002);
    exp_q.push_back(23'h000003);
    issue_go(5'd3);
    check("basic_rh0_reset", 32'(bus.cpu_reset), 32'd1);
    check("basic_rh0_busy",  32'(busy),          32'd1);
    tick();
    check("basic_rh1_reset", 32'(bus.cpu_reset), 32'd1);
    check("basic_rh1_write", 32'(bus.cpu_write), 32'd0);
    tick();
    check("basic_s0_reset",  32'(bus.cpu_reset),   32'd0);
    check("basic_s0_write",  32'(bus.cpu_write),   32'd1);
    check("basic_s0_word",   32'(bus.program_out), 32'h000001);
    wait_done(50);
    end_of_run("basic", 3, 5'd3);

    // Backpressure rerun from DONE: ready low 4 cycles on the second word.
    clear_counts();
    exp_q.push_back(23'h000001);
    exp_q.push_back(23'h000002);
    exp_q.push_back(23'h000003);
    issue_go(5'd3);
    check("bp_rh0_reset", 32'(bus.cpu_reset), 32'd1);
    check("bp_done_clr",  32'(done),          32'd0);
    check("bp_sent_clr",  32'(sent_count),    32'd0);
    tick();
    check("bp_rh1_reset", 32'(bus.cpu_reset), 32'd1);
    tick();
    check("bp_s0_reset",  32'(bus.cpu_reset), 32'd0);
    tick();
    bus.cpu_ready = 1'b0;
    repeat (4) tick();
    bus.cpu_ready = 1'b1;
    wait_done(50);
    check("bp_word2_cycles", 32'(hold_cnt), 32'd5);
    end_of_run("bp", 3, 5'd3);

    // Zero length: reset hold then start, no writes.
    clear_counts();
    issue_go(5'd0);
    tick();
    tick();
    check("zero_start", 32'(bus.cpu_start), 32'd1);
    check("zero_write", 32'(bus.cpu_write), 32'd0);
    wait_done(50);
    end_of_run("zero", 0, 5'd0);

    // Over length: 31 requested, clamped to 16.
    clear_counts();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(INSTR_W'(i + 1));
    issue_go(5'd31);
    wait_done(100);
    end_of_run("over", 16, 5'd16);

    // go and cfg_we during STREAM are ignored.
    clear_counts();
    bus.cpu_ready = 1'b0;
    exp_q.push_back(23'h000001);
    exp_q.push_back(23'h000002);
    exp_q.push_back(23'h000003);
    issue_go(5'd3);
    tick();
    tick();
    check("ign_in_stream", 32'(bus.cpu_write), 32'd1);
    go       = 1'b1;
    prog_len = 5'd1;
    cfg_write(4'd0, 23'h7FFFFF);
    go            = 1'b0;
    bus.cpu_ready = 1'b1;
    wait_done(50);
    end_of_run("ign", 3, 5'd3);
    repeat (3) tick();
    check("ign_no_restart_busy", 32'(busy), 32'd0);
    check("ign_no_restart_done", 32'(done), 32'd1);

    // image[0] must still hold its original word.
    clear_counts();
    exp_q.push_back(23'h000001);
    issue_go(5'd1);
    wait_done(50);
    end_of_run("img0", 1, 5'd1);

    // Rerun with a same-cycle image write.
    clear_counts();
    exp_q.push_back(23'h0000AA);
    exp_q.push_back(23'h000002);
    cfg_we   = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = 23'h0000AA;
    issue_go(5'd2);
    cfg_we   = 1'b0;
    check("rerun_rh0_reset", 32'(bus.cpu_reset), 32'd1);
    tick();
    check("rerun_rh1_reset", 32'(bus.cpu_reset), 32'd1);
    tick();
    check("rerun_s0_reset",  32'(bus.cpu_reset), 32'd0);
    wait_done(50);
    end_of_run("rerun", 2, 5'd2);

    // Asynchronous reset in the middle of STREAM.
    clear_counts();
    bus.cpu_ready = 1'b0;
    issue_go(5'd3);
    tick();
    tick();
    check("arst_pre_write", 32'(bus.cpu_write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_cpu_reset", 32'(bus.cpu_reset),   32'd1);
    check("arst_cpu_write", 32'(bus.cpu_write),   32'd0);
    check("arst_busy",      32'(busy),            32'd0);
    check("arst_done",      32'(done),            32'd0);
    check("arst_sent",      32'(sent_count),      32'd0);
    check("arst_prog_out",  32'(bus.program_out), 32'd0);
    bus.cpu_ready = 1'b1;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    check("arst_idle_reset", 32'(bus.cpu_reset), 32'd1);
    check("arst_idle_busy",  32'(busy),          32'd0);
    check("arst_writes",     32'(write_cnt),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
